// File: rtl/rs_cmd_gen.sv
// rs_cmd_gen: synchronises and debounces set/clear requests and issues
// mutually exclusive, fixed-width S/R pulses with an idle gap between them.
//
// state | meaning
// IDLE  | no command in flight; rising edges start a pulse directly
// SET_P | S held high for PULSE_LEN cycles
// CLR_P | R held high for PULSE_LEN cycles
// GAP   | one idle cycle; launches the pending command, if any
module rs_cmd_gen #(
  parameter int DEB_CYCLES = 4,
  parameter int PULSE_LEN  = 2,
  parameter int CW         = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic SET_IN,
  input  logic CLR_IN,
  output logic S,
  output logic R,
  output logic BUSY,
  output logic CONFLICT
);

  typedef enum logic [1:0] {IDLE, SET_P, CLR_P, GAP} state_t;
  typedef enum logic [1:0] {PEND_NONE, PEND_SET, PEND_CLR} pend_t;

  localparam logic [CW-1:0] DEB_TC   = CW'(DEB_CYCLES);
  localparam logic [CW-1:0] PULSE_TC = CW'(PULSE_LEN - 1);

  // bit 0 carries the set request, bit 1 the clear request
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    deb_q, deb_d, deb_dly_q;
  logic [CW-1:0] deb_cnt_q [2];
  logic [CW-1:0] deb_cnt_d [2];
  logic [1:0]    rise;
  logic          set_rise, clr_rise, both_rise;

  state_t        state_q, state_d;
  pend_t         pend_q, pend_d, pend_upd;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic          conflict_q, conflict_d;

  assign raw       = {CLR_IN, SET_IN};
  assign rise      = deb_q & ~deb_dly_q;
  assign set_rise  = rise[0];
  assign clr_rise  = rise[1];
  assign both_rise = set_rise & clr_rise;

  // debounce: flip once the synchronised value has disagreed for DEB_CYCLES+1 samples
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_TC) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // input synchronisers, debounce state and edge-detect delay
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_q        <= '0;
      deb_dly_q    <= '0;
      deb_cnt_q[0] <= '0;
      deb_cnt_q[1] <= '0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      deb_q        <= deb_d;
      deb_dly_q    <= deb_q;
      deb_cnt_q[0] <= deb_cnt_d[0];
      deb_cnt_q[1] <= deb_cnt_d[1];
    end
  end

  // pending command as it stands after this cycle's edges (last writer wins)
  always_comb begin
    pend_upd = pend_q;
    if (both_rise)     pend_upd = PEND_NONE;
    else if (set_rise) pend_upd = PEND_SET;
    else if (clr_rise) pend_upd = PEND_CLR;
  end

  // next-state, pulse timer and pending/conflict logic
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pcnt_d     = pcnt_q;
    conflict_d = 1'b0;
    case (state_q)
      IDLE: begin
        pend_d = PEND_NONE;
        if (both_rise) begin
          conflict_d = 1'b1;
        end else if (set_rise) begin
          state_d = SET_P;
          pcnt_d  = PULSE_TC;
        end else if (clr_rise) begin
          state_d = CLR_P;
          pcnt_d  = PULSE_TC;
        end
      end
      SET_P, CLR_P: begin
        pend_d     = pend_upd;
        conflict_d = both_rise;
        if (pcnt_q == '0) state_d = GAP;
        else              pcnt_d  = pcnt_q - 1'b1;
      end
      GAP: begin
        conflict_d = both_rise;
        pend_d     = PEND_NONE;
        pcnt_d     = PULSE_TC;
        if (pend_upd == PEND_SET)      state_d = SET_P;
        else if (pend_upd == PEND_CLR) state_d = CLR_P;
        else                           state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      pend_q     <= PEND_NONE;
      pcnt_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pcnt_q     <= pcnt_d;
      conflict_q <= conflict_d;
    end
  end

  assign S        = (state_q == SET_P);
  assign R        = (state_q == CLR_P);
  assign BUSY     = (state_q != IDLE);
  assign CONFLICT = conflict_q;

endmodule

// File: tb/tb_rs_cmd_gen.sv
// Bench for rs_cmd_gen: directed scenarios followed by random request
// traffic, all checked cycle by cycle against a timeline-based model.
module tb_rs_cmd_gen;

  localparam int DEB = 4;
  localparam int PL  = 2;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic SET_IN = 1'b0;
  logic CLR_IN = 1'b0;
  logic S, R, BUSY, CONFLICT;

  int n_pass = 0;
  int n_total = 0;

  rs_cmd_gen #(.DEB_CYCLES(DEB), .PULSE_LEN(PL), .CW(8)) dut (
    .CLK(CLK), .RST(RST), .SET_IN(SET_IN), .CLR_IN(CLR_IN),
    .S(S), .R(R), .BUSY(BUSY), .CONFLICT(CONFLICT)
  );

  always #5 CLK = ~CLK;

  // model: edge index, sync pipes, debounced values, and command timeline
  int n = 0;
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_deb [2];
  bit m_dd [2];
  int last_eq [2];
  bit m_act = 0;
  int m_start = 0;
  int m_kind = 0;   // 1 = set pulse, 2 = clear pulse
  int m_pend = 0;   // 0 none, 1 set, 2 clear
  bit m_conf = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_edge();
    bit rs, rc, busy, samp;
    bit in_v [2];
    n++;
    in_v[0] = SET_IN;
    in_v[1] = CLR_IN;
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_dd[i] = 0; last_eq[i] = n;
      end
      m_act = 0; m_pend = 0; m_conf = 0;
      return;
    end
    rs = m_deb[0] & ~m_dd[0];
    rc = m_deb[1] & ~m_dd[1];
    m_conf = 0;
    busy = m_act && ((n - 1 - m_start) <= PL);
    if (!busy) begin
      m_act = 0;
      m_pend = 0;
      if (rs && rc) m_conf = 1;
      else if (rs) begin m_act = 1; m_start = n; m_kind = 1; end
      else if (rc) begin m_act = 1; m_start = n; m_kind = 2; end
    end else begin
      if (rs && rc) begin m_pend = 0; m_conf = 1; end
      else if (rs) m_pend = 1;
      else if (rc) m_pend = 2;
      if ((n - 1 - m_start) == PL) begin
        if (m_pend != 0) begin m_start = n; m_kind = m_pend; m_pend = 0; end
        else m_act = 0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      m_dd[i] = m_deb[i];
      samp = m_s2[i];
      if (samp == m_deb[i]) last_eq[i] = n;
      else if ((n - last_eq[i]) >= DEB + 1) begin
        m_deb[i] = ~m_deb[i];
        last_eq[i] = n;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = in_v[i];
    end
  endtask

  task automatic tick();
    int es, er, eb;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    es = (m_act && (n - m_start) < PL && m_kind == 1) ? 1 : 0;
    er = (m_act && (n - m_start) < PL && m_kind == 2) ? 1 : 0;
    eb = (m_act && (n - m_start) <= PL) ? 1 : 0;
    chk("S", int'(S), es);
    chk("R", int'(R), er);
    chk("BUSY", int'(BUSY), eb);
    chk("CONFLICT", int'(CONFLICT), int'(m_conf));
    chk("S_and_R", int'(S & R), 0);
  endtask

  // tick a number of cycles, recording first S/CONFLICT offset and high-cycle counts
  task automatic run(input int cyc, output int first_s, output int first_c,
                     output int cs, output int cr, output int cb, output int cc);
    first_s = -1; first_c = -1; cs = 0; cr = 0; cb = 0; cc = 0;
    for (int j = 0; j < cyc; j++) begin
      tick();
      if (S && first_s < 0) first_s = j;
      if (CONFLICT && first_c < 0) first_c = j;
      cs += int'(S); cr += int'(R); cb += int'(BUSY); cc += int'(CONFLICT);
    end
  endtask

  initial begin
    int fs, fc, cs, cr, cb, cc, tot_s;
    int set_hold, clr_hold;

    // reset with both requests high: outputs stay quiet
    RST = 1; SET_IN = 1; CLR_IN = 1;
    run(2, fs, fc, cs, cr, cb, cc);
    chk("rst_S", cs, 0); chk("rst_R", cr, 0); chk("rst_BUSY", cb, 0); chk("rst_CONF", cc, 0);
    RST = 0; CLR_IN = 0;
    run(12, fs, fc, cs, cr, cb, cc);
    chk("post_rst_latency", fs, 7);
    chk("post_rst_S_len", cs, 2);
    SET_IN = 0;
    run(15, fs, fc, cs, cr, cb, cc);

    // single held set request
    SET_IN = 1;
    run(20, fs, fc, cs, cr, cb, cc);
    chk("set_latency", fs, 7); chk("set_S_len", cs, 2);
    chk("set_BUSY_len", cb, 3); chk("set_R", cr, 0);
    SET_IN = 0;
    run(15, fs, fc, cs, cr, cb, cc);

    // bounce 3 high / 3 low, then a long hold
    SET_IN = 1; run(3, fs, fc, cs, cr, cb, cc); tot_s = cs;
    SET_IN = 0; run(3, fs, fc, cs, cr, cb, cc); tot_s += cs;
    chk("bounce_filtered", tot_s, 0);
    SET_IN = 1; run(13, fs, fc, cs, cr, cb, cc);
    chk("bounce_then_hold_S", cs, 2);
    SET_IN = 0;
    run(15, fs, fc, cs, cr, cb, cc);

    // simultaneous set and clear
    SET_IN = 1; CLR_IN = 1;
    run(15, fs, fc, cs, cr, cb, cc);
    chk("conf_count", cc, 1); chk("conf_latency", fc, 7);
    chk("conf_S", cs, 0); chk("conf_R", cr, 0); chk("conf_BUSY", cb, 0);
    SET_IN = 0; CLR_IN = 0;
    run(15, fs, fc, cs, cr, cb, cc);

    // clear arrives during the set pulse: S, gap, R, trailing gap
    SET_IN = 1; run(1, fs, fc, cs, cr, cb, cc);
    CLR_IN = 1; run(20, fs, fc, cs, cr, cb, cc);
    chk("queued_S", cs, 2); chk("queued_R", cr, 2); chk("queued_BUSY", cb, 6);
    SET_IN = 0; CLR_IN = 0;
    run(15, fs, fc, cs, cr, cb, cc);

    // reset during the first S cycle with a clear pending
    SET_IN = 1; run(1, fs, fc, cs, cr, cb, cc);
    CLR_IN = 1; run(7, fs, fc, cs, cr, cb, cc);
    chk("mid_rst_S_start", fs, 6);
    RST = 1; SET_IN = 0; CLR_IN = 0;
    run(1, fs, fc, cs, cr, cb, cc);
    chk("mid_rst_S_drop", cs, 0); chk("mid_rst_BUSY", cb, 0);
    RST = 0;
    run(20, fs, fc, cs, cr, cb, cc);
    chk("mid_rst_no_R", cr, 0); chk("mid_rst_no_S", cs, 0); chk("mid_rst_idle", cb, 0);

    // random traffic: mixed bounces, long holds, overlap and rare resets
    set_hold = 0; clr_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (set_hold == 0) begin
        SET_IN = ~SET_IN;
        set_hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 20);
      end
      if (clr_hold == 0) begin
        CLR_IN = ~CLR_IN;
        clr_hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 20);
      end
      set_hold--; clr_hold--;
      RST = ($urandom_range(0, 399) == 0);
      tick();
    end
    RST = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
